stage_sequencer: RTL

Sequences the pipeline stages of one accelerator run. A single-cycle `start_pulse` (produced by the rising-edge detector on the host's start level) launches the run. The block then issues a one-cycle start pulse to each stage in order and waits for each stage's done pulse before launching the next. At the end it reports completion, timeouts, dropped starts and the run length in cycles. It sits directly downstream of the start edge detector and upstream of the per-stage controllers.

---
 rtl/stage_sequencer_if.sv | 41 ++++
 rtl/stage_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// Host/stage-controller side signals of the stage sequencer.
// The sequencer connects through the slave modport; the host or bench drives
// through the master modport.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
);
    logic                  start_pulse;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_start;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  overrun;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output start_pulse,
        output abort,
        output stage_done,
        input  stage_start,
        input  busy,
        input  done,
        input  err,
        input  overrun,
        input  cycle_count
    );

    modport slave (
        input  start_pulse,
        input  abort,
        input  stage_done,
        output stage_start,
        output busy,
        output done,
        output err,
        output overrun,
        output cycle_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Launches NUM_STAGES pipeline stages in order, one at a time, waiting for each
// stage's done pulse. Reports completion, per-stage timeout, ignored starts and
// the run length in cycles. All outputs are registered.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | no run in progress; a start_pulse begins a new run
//  LAUNCH | stage_start[idx] pulses for this cycle; wait timer is reloaded
//  WAIT   | waiting for stage_done[idx] or for the wait timer to expire
//  FINISH | done pulses for this cycle, then back to IDLE
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    stage_sequencer_if.slave sb
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The wait timer is a down-counter: reloaded with TIMEOUT-1 at launch and
    // expiring on the WAIT cycle where it reads zero, i.e. the TIMEOUT-th one.
    localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] timer;
    logic             run_active;

    assign run_active = (state != IDLE);

    // Sequencing FSM with registered outputs; abort preempts every other transition.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            idx            <= '0;
            timer          <= '0;
            sb.stage_start <= '0;
            sb.busy        <= 1'b0;
            sb.done        <= 1'b0;
            sb.err         <= 1'b0;
            sb.overrun     <= 1'b0;
            sb.cycle_count <= '0;
        end else begin
            sb.stage_start <= '0;
            sb.done        <= 1'b0;

            // A start during a run is dropped but remembered.
            if (run_active && sb.start_pulse) begin
                sb.overrun <= 1'b1;
            end

            if (run_active && sb.abort) begin
                // cycle_count freezes at the value seen in the abort cycle.
                state   <= IDLE;
                sb.busy <= 1'b0;
            end else begin
                if (run_active && (sb.cycle_count != CNT_MAX)) begin
                    sb.cycle_count <= sb.cycle_count + 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        if (sb.start_pulse) begin
                            idx               <= '0;
                            sb.cycle_count    <= '0;
                            sb.err            <= 1'b0;
                            sb.overrun        <= 1'b0;
                            sb.stage_start[0] <= 1'b1;
                            sb.busy           <= 1'b1;
                            state             <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        timer <= TMR_LOAD;
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (sb.stage_done[idx]) begin
                            if (idx == IDX_LAST) begin
                                sb.done <= 1'b1;
                                state   <= FINISH;
                            end else begin
                                idx                         <= idx + 1'b1;
                                sb.stage_start[idx + 1'b1] <= 1'b1;
                                state                       <= LAUNCH;
                            end
                        end else if ((TIMEOUT != 0) && (timer == '0)) begin
                            sb.err  <= 1'b1;
                            sb.busy <= 1'b0;
                            state   <= IDLE;
                        end else if (TIMEOUT != 0) begin
                            timer <= timer - 1'b1;
                        end
                    end
                    FINISH: begin
                        sb.busy <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
